// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data accesses.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [3:0]        data_be,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [0:0]          state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                owner_q, owner_d;
  logic                store_q, store_d;

  logic grant_data;
  logic grant_fetch;
  logic ack_cycle;
  logic issue;
  logic ack_live;
  logic is_store;

  // Next-state: arbitration in IDLE, latency countdown in WAIT.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    store_d      = store_q;
    grant_data   = 1'b0;
    grant_fetch  = 1'b0;
    ack_cycle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_data  = data_req && !(fetch_req && (starve_cnt_q == STARVE_LIM));
        grant_fetch = fetch_req && !grant_data;
        if (grant_data || grant_fetch) begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_INIT;
          owner_d   = grant_data ? OWN_DATA : OWN_FETCH;
          store_d   = grant_data && data_we;
        end
        if (!fetch_req || grant_fetch) begin
          starve_cnt_d = '0;
        end else if (grant_data && (starve_cnt_q < STARVE_LIM)) begin
          starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          ack_cycle = 1'b1;
          state_d   = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_FETCH;
      store_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
    end
  end

  // Outputs are qualified by rst so everything reads 0 while reset is held.
  assign issue    = !rst && (grant_data || grant_fetch);
  assign ack_live = !rst && ack_cycle;
  assign is_store = issue && grant_data && data_we;

  assign mem_en    = issue;
  assign mem_we    = is_store;
  assign mem_be    = is_store ? data_be : (issue ? 4'hF : 4'h0);
  assign mem_addr  = issue ? (grant_data ? data_addr : fetch_addr) : '0;
  assign mem_wdata = is_store ? data_wdata : '0;

  assign fetch_ack   = ack_live && (owner_q == OWN_FETCH);
  assign fetch_rdata = fetch_ack ? mem_rdata : '0;
  assign data_ack    = ack_live && (owner_q == OWN_DATA);
  assign data_rdata  = (data_ack && !store_q) ? mem_rdata : '0;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores driven by the MemRead/MemWrite controls) of the pipelined RISC-V core. It sequences one access at a time through an issue/wait/acknowledge state machine. Data accesses take priority over fetches, and a starvation counter guarantees fetch progress. The pipeline stalls on the `*_req && !*_ack` condition of each requester.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width, fixed at 4 bytes per word.
- `MEM_LAT`, 1: cycles from issue to memory read data valid; legal range 1..7.
- `STARVE_MAX`, 2: consecutive data grants allowed while a fetch is pending; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_req` in 1: IF requests a word read; held until `fetch_ack`.
- `fetch_addr` in ADDR_W: fetch byte address; stable while `fetch_req`.
- `fetch_ack` out 1: one-cycle completion pulse.
- `fetch_rdata` out DATA_W: instruction word; valid only while `fetch_ack`, 0 otherwise.
- `data_req` in 1: MEM stage requests an access (MemRead|MemWrite); held until `data_ack`.
- `data_we` in 1: 1 = store, 0 = load.
- `data_addr` in ADDR_W: data byte address.
- `data_wdata` in DATA_W: store data.
- `data_be` in 4: byte enables for stores.
- `data_ack` out 1: one-cycle completion pulse, for both loads and stores.
- `data_rdata` out DATA_W: load data; valid only while `data_ack`, 0 otherwise.
- `mem_en` out 1: memory access strobe; memory samples it on the next rising edge.
- `mem_we` out 1: write strobe; valid with `mem_en`.
- `mem_be` out 4: byte enables; all ones for reads.
- `mem_addr` out ADDR_W: address to memory.
- `mem_wdata` out DATA_W: write data to memory.
- `mem_rdata` in DATA_W: memory read data, valid MEM_LAT cycles after issue.

## Operation
- **States.**
  - IDLE: no access outstanding. If any request is present, select a winner, drive the `mem_*` outputs combinationally from it, and go to WAIT.
  - WAIT: access outstanding. A latency counter `lat_cnt` loads MEM_LAT-1 on issue and decrements each WAIT cycle.
  - When `lat_cnt`==0 in WAIT, this is the ack cycle: pulse the owner's ack, pass `mem_rdata` through to the owner's rdata, and return to IDLE.
- **Owner register.** `owner` (FETCH/DATA) is latched at issue. Ack and rdata routing use `owner`, never the current request lines.
- **Arbitration in IDLE.**
  - Only one request present: grant it.
  - Both present: grant DATA, unless `starve_cnt`==STARVE_MAX, in which case grant FETCH.
- **Starvation counter (`starve_cnt`, 4 bits).**
  - Increments on a DATA grant while `fetch_req` is high.
  - Clears on any FETCH grant and in any IDLE cycle where `fetch_req` is low.
  - Saturates at STARVE_MAX.
- **Outputs outside the issue cycle.** `mem_en`=0. `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` are 0.
- **Write data path.** Stores: `mem_we`=1, `mem_be`=`data_be`, `mem_wdata`=`data_wdata`. Fetches and loads: `mem_we`=0, `mem_be`=4'hF.
- **Dropped request.** If a requester drops its req during WAIT, the access still completes and the ack still pulses. Requesters must ignore such an ack.
- **New request during WAIT.** Not sampled until the next IDLE cycle.
- **Reset.**
  - Asynchronous. FSM goes to IDLE; `lat_cnt`, `starve_cnt`, `owner` go to 0.
  - All outputs are 0 during and immediately after reset.
  - An outstanding access is abandoned with no ack, and any late `mem_rdata` is ignored.

## Timing
- Issue cycle T: IDLE with a request present, `mem_en`=1.
- Ack cycle: T+MEM_LAT.
- Next earliest issue: T+MEM_LAT+1.
- Throughput: one access per MEM_LAT+1 cycles.
- Ack and rdata are combinational from registered state plus `mem_rdata`. No extra register stage.
- Request-to-ack latency, uncontended: MEM_LAT cycles.

## Test plan
- **Fetch only.** MEM_LAT=2; `fetch_req` at cycle 0 with `fetch_addr`=0x40, memory returns 0x00500093.
  - Required: `mem_en`=1 at cycle 0 with `mem_addr`=0x40.
  - Required: `fetch_ack`=1 and `fetch_rdata`=0x00500093 at cycle 2 only; next issue at cycle 3.
- **Simultaneous requests.** `fetch_req` and `data_req` (load, 0x100) both rise at cycle 0, MEM_LAT=1.
  - Required: data issues at cycle 0 and `data_ack` pulses at cycle 1.
  - Required: fetch issues at cycle 2 and `fetch_ack` pulses at cycle 3.
- **Starvation guard.** STARVE_MAX=2, MEM_LAT=1; `data_req` and `fetch_req` held continuously.
  - Required grant order: DATA, DATA, FETCH, DATA, DATA, FETCH.
  - Required: issue cycles 0, 2, 4, 6, 8, 10.
- **Store.** `data_we`=1, `data_addr`=0x200, `data_wdata`=0xDEADBEEF, `data_be`=4'b0011.
  - Required issue-cycle outputs: `mem_we`=1, `mem_be`=0011, `mem_wdata`=0xDEADBEEF.
  - Required: `data_ack` at T+MEM_LAT with `data_rdata`=0.
- **Reset mid-operation.** MEM_LAT=3; assert `rst` asynchronously one cycle after a fetch issue.
  - Required: all outputs go 0 immediately and no `fetch_ack` occurs.
  - Required: after deassert, a held `fetch_req` reissues on the first clock edge.
- **Dropped request.** `data_req` dropped during WAIT.
  - Required: `data_ack` still pulses at T+MEM_LAT.
  - Required: a pending `fetch_req` issues the following cycle.
